seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display. It scans one digit per refresh slot and decodes 4-bit values to active-low segment patterns, with optional hex A–F glyphs. It also drives per-digit decimal points, leading-zero suppression and a global enable. It sits between the datapath registers (counters, ALU results) and the board-level segment/anode pins, and replaces the single-digit registered decoder.

## Interface
- DIGITS, 4: number of digits scanned; ≥1.
- REFRESH_DIV, 50000: clock cycles per digit slot; ≥2.
- HEX_EN, 1: 1 = values 10–15 show A b C d E F; 0 = values 10–15 blank.
- AN_ACTIVE_LOW, 1: anode polarity; 1 = an active digit drives 0.
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  display enable; 0 blanks all outputs while scanning continues.
- D  in  4*DIGITS  digit values; D[4i+3:4i] is digit i; digit 0 is least significant (rightmost).
- DP  in  DIGITS  decimal point request per digit; 1 = lit.
- LZ_SUPPRESS  in  1  1 = blank leading zeros.
- SEG  out  8  active-low segments {a,b,c,d,e,f,g,dp}; SEG[7]=a, SEG[0]=dp.
- AN  out  DIGITS  digit select, one-hot active per AN_ACTIVE_LOW.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- Digit index idx advances on tick: 0→1→…→DIGITS-1→0.
- Frame snapshot register holds {D, DP, LZ_SUPPRESS}.
  - It loads in the first cycle after RST deasserts.
  - It also loads on every tick where idx wraps DIGITS-1→0.
  - Mid-frame input changes are invisible until the next frame, so there is no tearing.
- Decode uses the snapshot value v of digit idx:
  - v 0–9 gives 03,9F,25,0D,99,49,41,1F,01,09 (hex, bits a..dp).
  - v 10–15 with HEX_EN=1 gives 11,C1,63,85,61,71.
  - v 10–15 with HEX_EN=0 gives FF.
  - SEG[0] = ~DP_snap[idx], applied after the glyph. It applies to suppressed digits too.
- Leading-zero suppression: digit i is blank (glyph FF) when all of these hold:
  - LZ_SUPPRESS_snap = 1;
  - i ≠ 0;
  - v_j = 0 for every j ≥ i.
  - Digit 0 is never suppressed.
- Dead time: AN is inactive for exactly the first clock of every slot. This prevents ghosting while SEG changes.
- EN=0: SEG = FF and AN = all inactive from the next clock. cnt, idx and snapshot keep running. EN=1 resumes at the current slot position.
- Reset: cnt=0, idx=0, snapshot=0, SEG=FF, AN=all inactive (all 1s when AN_ACTIVE_LOW=1). Reset mid-frame aborts the slot immediately with no partial dead-time carry-over.

## Timing
- SEG and AN are registered outputs with no combinational path from inputs.
- In the slot for digit i, cycles are counted from the clock edge where cnt becomes 0:
  - cycle 0: AN inactive, SEG = glyph(i);
  - cycles 1..REFRESH_DIV-1: AN = onehot(i), SEG unchanged.
- Latency from a D change to visibility: up to one frame (DIGITS*REFRESH_DIV cycles) plus 1.
- After RST falls, the first visible digit (digit 0) lights at cycle 2: snapshot load, glyph register, then AN after dead time.
- Digit period is REFRESH_DIV cycles; frame period is DIGITS*REFRESH_DIV cycles.
- cnt width is $clog2(REFRESH_DIV); idx width is max(1,$clog2(DIGITS)). Both wrap explicitly and never rely on power-of-two overflow.

## Structure
- Package seg7_pkg holds:
  - the glyph constants SEG_0..SEG_F and SEG_BLANK = 8'hFF;
  - the segment bit-position localparams.
- Sub-module seg7_glyph: combinational, inputs v[3:0], dp, blank, hex_en; output seg[7:0]. It is the only place glyphs are encoded.
- The top holds the prescaler, idx, snapshot, LZ mask generation, dead-time logic and the output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1.

- Reset/scan: hold RST 3 cycles, then D=16'h1234, DP=0, EN=1.
  - Expect SEG=FF, AN=1111 during reset.
  - Then the slots run digit 0..3 with AN=1110,1101,1011,0111, each preceded by one 1111 cycle.
  - SEG sequence is 99,0D,25,9F.
- Hex/blank: D=16'hABCD with HEX_EN=1 gives 85,63,C1,11. Rebuilt with HEX_EN=0, every digit is FF.
- Leading zeros: D=16'h0050, LZ_SUPPRESS=1 gives digit 3 = FF, digit 2 = FF, digit 1 = 49, digit 0 = 03. D=16'h0000 gives only digit 0 = 03.
- Snapshot: change D from 1234 to 5678 while digit 1 is lit. Digits 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5.
- DP and EN: DP=4'b0010 makes digit 1's SEG[0]=0. EN dropped for 5 cycles gives SEG=FF, AN=1111 from the next clock. After EN returns, the scan position has advanced as if uninterrupted.
- Mid-frame reset: assert RST during digit 2. The next clock shows SEG=FF, AN=1111, and the scan restarts at digit 0 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyph patterns
// ordered {a,b,c,d,e,f,g,dp} and the bit position of each segment.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // dp bit is left at 1 (off) in every glyph; it is applied separately
    localparam seg_t SEG_0 = 8'h03;
    localparam seg_t SEG_1 = 8'h9F;
    localparam seg_t SEG_2 = 8'h25;
    localparam seg_t SEG_3 = 8'h0D;
    localparam seg_t SEG_4 = 8'h99;
    localparam seg_t SEG_5 = 8'h49;
    localparam seg_t SEG_6 = 8'h41;
    localparam seg_t SEG_7 = 8'h1F;
    localparam seg_t SEG_8 = 8'h01;
    localparam seg_t SEG_9 = 8'h09;
    localparam seg_t SEG_A = 8'h11;
    localparam seg_t SEG_B = 8'hC1;
    localparam seg_t SEG_C = 8'h63;
    localparam seg_t SEG_D = 8'h85;
    localparam seg_t SEG_E = 8'h61;
    localparam seg_t SEG_F = 8'h71;

    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit value to active-low segment decoder with optional hex
// glyphs, blanking and a decimal point that survives blanking.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] v,
    input  logic       dp,
    input  logic       blank,
    input  logic       hex_en,
    output logic [7:0] seg
);

    seg_t glyph;

    always_comb begin
        glyph = SEG_BLANK;
        case (v)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = hex_en ? SEG_A : SEG_BLANK;
            4'hB: glyph = hex_en ? SEG_B : SEG_BLANK;
            4'hC: glyph = hex_en ? SEG_C : SEG_BLANK;
            4'hD: glyph = hex_en ? SEG_D : SEG_BLANK;
            4'hE: glyph = hex_en ? SEG_E : SEG_BLANK;
            4'hF: glyph = hex_en ? SEG_F : SEG_BLANK;
        endcase
    end

    always_comb begin
        seg             = blank ? SEG_BLANK : glyph;
        seg[SEG_DP_BIT] = ~dp;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver: prescaled digit scan, frame
// snapshot of the inputs, leading-zero blanking and one dead cycle per slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit HEX_EN        = 1'b1,
    parameter bit AN_ACTIVE_LOW = 1'b1
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [4*DIGITS-1:0]   D,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LZ_SUPPRESS,
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     AN
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // LOAD captures the snapshot, PRIME opens digit 0's slot with its dead cycle
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]            state_reg,   state_next;
    logic [CW-1:0]         cnt_reg,     cnt_next;
    logic [IW-1:0]         idx_reg,     idx_next;
    logic [4*DIGITS-1:0]   snap_d_reg,  snap_d_next;
    logic [DIGITS-1:0]     snap_dp_reg, snap_dp_next;
    logic                  snap_lz_reg, snap_lz_next;
    logic [7:0]            seg_reg,     seg_next;
    logic [DIGITS-1:0]     an_reg,      an_next;

    logic                  tick;
    logic                  load_snap;
    logic [3:0]            digit_next [DIGITS];
    logic [DIGITS-1:0]     lz_blank;
    logic [DIGITS-1:0]     an_onehot;
    logic [3:0]            cur_v;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [7:0]            glyph_seg;

    assign tick = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        load_snap  = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                load_snap  = 1'b1;
                cnt_next   = '0;
                idx_next   = '0;
                state_next = ST_PRIME;
            end
            ST_PRIME: begin
                cnt_next   = '0;
                idx_next   = '0;
                state_next = ST_RUN;
            end
            default: begin
                if (tick) begin
                    cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        idx_next  = '0;
                        load_snap = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        snap_d_next  = snap_d_reg;
        snap_dp_next = snap_dp_reg;
        snap_lz_next = snap_lz_reg;
        if (load_snap) begin
            snap_d_next  = D;
            snap_dp_next = DP;
            snap_lz_next = LZ_SUPPRESS;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_next[gi] = snap_d_next[4*gi +: 4];
            assign an_onehot[gi]  = (idx_next == IW'(gi));
        end
    endgenerate

    // Walk from the most significant digit down; a digit is a leading zero
    // while every digit at or above it is zero. Digit 0 always shows.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (digit_next[i] == 4'd0);
            lz_blank[i] = snap_lz_next && (i != 0) && all_zero;
        end
    end

    // Decode from the post-edge slot so the glyph lands with the dead cycle
    assign cur_v     = digit_next[idx_next];
    assign cur_dp    = snap_dp_next[idx_next];
    assign cur_blank = lz_blank[idx_next];

    seg7_glyph u_glyph (
        .v      (cur_v),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .hex_en (HEX_EN),
        .seg    (glyph_seg)
    );

    always_comb begin
        seg_next = glyph_seg;
        an_next  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
        if (state_reg == ST_LOAD || !EN) begin
            seg_next = SEG_BLANK;
            an_next  = AN_OFF;
        end else if (cnt_next == '0) begin
            an_next = AN_OFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_LOAD;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            snap_d_reg  <= '0;
            snap_dp_reg <= '0;
            snap_lz_reg <= 1'b0;
            seg_reg     <= SEG_BLANK;
            an_reg      <= AN_OFF;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            snap_d_reg  <= snap_d_next;
            snap_dp_reg <= snap_dp_next;
            snap_lz_reg <= snap_lz_next;
            seg_reg     <= seg_next;
            an_reg      <= an_next;
        end
    end

    assign SEG = seg_reg;
    assign AN  = an_reg;

endmodule
